regpair_file_param: RTL
=======================

// Module: regpair_file_param
// PURPOSE
//  Parametrised register-pair file for the 8085 datapath: BC, DE, HL, WZ, PC, SP by default.
//  Byte-wide access to the high and low halves of each pair from the internal data bus.
//  Address latch drives the external address bus.
//  Incrementer/decrementer writes pair+/-1 back while the pre-update address is still on the bus.
//  Executes DE<->HL exchange (XCHG) in one cycle.
// PARAMETERS
//  WIDTH   8  byte width; a pair is 2*WIDTH bits
//  NPAIRS  6  number of register pairs (index 0..NPAIRS-1)
//  SEL_W   $clog2(NPAIRS)  width of pair-select fields
//  IDX_DE  1  pair index used as first operand of XCHG
//  IDX_HL  2  pair index used as second operand of XCHG
// PORTS
//  clk       in   1        clock; all state updates on rising edge
//  rst       in   1        asynchronous, active-low reset
//  op_valid  in   1        command strobe
//  op        in   3        0 NOP, 1 WR_LO, 2 WR_HI, 3 RD_LO, 4 RD_HI, 5 LD_ADDR, 6 INCDEC, 7 XCHG
//  sel       in   SEL_W    target pair index
//  dec       in   1        INCDEC direction: 0 = +1, 1 = -1
//  data_in   in   WIDTH    write data from internal bus
//  op_ready  out  1        command accepted when op_valid && op_ready
//  data_out  out  WIDTH    read data, valid while data_oe = 1
//  data_oe   out  1        read-data valid/drive enable, 1-cycle pulse
//  addr_out  out  2*WIDTH  address latch contents
//  err       out  1        1-cycle pulse: accepted op had sel >= NPAIRS
// BEHAVIOUR
//  Reset (rst=0, async)
//   - All pairs are 0, address latch is 0, incdec latch is 0.
//   - data_out=0, data_oe=0, err=0, op_ready=1, FSM=IDLE.
//   - Commands are ignored while rst=0.
//  FSM
//   - IDLE: op_ready=1. Accepting INCDEC -> WB; every other op stays in IDLE.
//   - WB: op_ready=0; op_valid is ignored. Always returns to IDLE after 1 cycle.
//  Ops (take effect at the accept edge T)
//   - WR_LO / WR_HI: pair[sel][WIDTH-1:0] or [2W-1:W] <= data_in. The other half is unchanged.
//   - RD_LO / RD_HI: at T, data_out <= selected half and data_oe <= 1. data_oe is valid in cycle T+1 only.
//     - Latency is 1. data_out holds its last value after data_oe drops.
//   - LD_ADDR: addr_latch <= pair[sel]; addr_out shows it from T+1.
//   - INCDEC at T: addr_latch <= pair[sel]; incdec latch <= pair[sel] +/- 1 (mod 2^(2W)).
//   - INCDEC at T+1 (WB): pair[sel] <= incdec latch; addr_latch is unchanged.
//     - Net result: pre-update value on addr_out, updated value in the pair.
//     - Wrap: max+1 -> 0; 0-1 -> all ones. No carry/borrow output.
//   - XCHG: pair[IDX_DE] <= pair[IDX_HL] and pair[IDX_HL] <= pair[IDX_DE] in one edge. sel is ignored.
//   - NOP: no state change.
//  Boundary conditions
//   - data_oe=0 in every cycle not immediately following an accepted RD_*.
//   - Out-of-range sel with ops 1-6: no state change, FSM stays IDLE, data_oe stays 0, err=1 in T+1.
//   - op_valid during WB: dropped, not queued. The master must hold the command until op_ready=1.
//   - Back-to-back: WR then RD of the same half on consecutive accepts returns the new data.
//   - Accept immediately after WB: sees the written-back value.
//   - Reset asserted during WB: the writeback is abandoned and all state returns to reset values.
// TESTING
//  1. Reset, then RD_LO/RD_HI on every pair -> data_out=0x00, data_oe high for exactly 1 cycle each.
//  2. WR_HI(HL)=0x12, WR_LO(HL)=0x34, LD_ADDR(HL) -> addr_out=0x1234 next cycle.
//     - RD_HI -> 0x12, RD_LO -> 0x34.
//  3. PC=0xFFFF, INCDEC dec=0 -> addr_out=0xFFFF and op_ready=0 for 1 cycle.
//     - Then PC=0x0000. SP=0x0000, dec=1 -> SP=0xFFFF.
//  4. DE=0xAAAA, HL=0x5555, XCHG -> DE=0x5555, HL=0xAAAA in one cycle; other pairs unchanged.
//  5. sel=7 with WR_LO data 0xFF -> err pulse 1 cycle, all pairs unchanged, data_oe=0.
//  6. PC=0x0100, INCDEC dec=0, rst=0 pulse during WB -> PC=0x0000, addr_out=0, FSM IDLE, op_ready=1.

Source files
------------

// File: rtl/regpair_file_param.sv
// 8085 register-pair file: byte access, address latch, incdec writeback, XCHG.
// Pairs default to BC, DE, HL, WZ, PC, SP at indices 0..5.
module regpair_file_param #(
  parameter int WIDTH  = 8,
  parameter int NPAIRS = 6,
  parameter int SEL_W  = $clog2(NPAIRS),
  parameter int IDX_DE = 1,
  parameter int IDX_HL = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [2:0]         op,
  input  logic [SEL_W-1:0]   sel,
  input  logic               dec,
  input  logic [WIDTH-1:0]   data_in,
  output logic               op_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               data_oe,
  output logic [2*WIDTH-1:0] addr_out,
  output logic               err
);

  localparam int PW = 2 * WIDTH;
  localparam logic [SEL_W-1:0] DE = SEL_W'(IDX_DE);
  localparam logic [SEL_W-1:0] HL = SEL_W'(IDX_HL);

  typedef enum logic [2:0] {
    OP_NOP,
    OP_WR_LO,
    OP_WR_HI,
    OP_RD_LO,
    OP_RD_HI,
    OP_LD_ADDR,
    OP_INCDEC,
    OP_XCHG
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_WB
  } state_e;

  state_e           state_q;
  state_e           state_d;
  op_e              cmd;
  logic             accept;
  logic             sel_ok;
  logic [PW-1:0]    sel_val;
  logic [PW-1:0]    pair_q [NPAIRS];
  logic [PW-1:0]    addr_q;
  logic [PW-1:0]    incdec_q;
  logic [SEL_W-1:0] wb_sel_q;

  assign cmd      = op_e'(op);
  assign op_ready = (state_q == S_IDLE);
  assign accept   = op_valid && op_ready;
  assign sel_ok   = (32'(sel) < NPAIRS);
  assign addr_out = addr_q;

  always_comb begin
    sel_val = '0;
    if (sel_ok) sel_val = pair_q[sel];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && cmd == OP_INCDEC && sel_ok)
          state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bad sel squashes ops 1-6; XCHG ignores sel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NPAIRS; i++)
        pair_q[i] <= '0;
      addr_q   <= '0;
      incdec_q <= '0;
      wb_sel_q <= '0;
      data_out <= '0;
      data_oe  <= 1'b0;
      err      <= 1'b0;
    end else begin
      data_oe <= 1'b0;
      err     <= 1'b0;
      if (state_q == S_WB)
        pair_q[wb_sel_q] <= incdec_q;
      if (accept) begin
        unique case (cmd)
          OP_WR_LO: begin
            if (sel_ok) pair_q[sel][WIDTH-1:0] <= data_in;
          end
          OP_WR_HI: begin
            if (sel_ok) pair_q[sel][PW-1:WIDTH] <= data_in;
          end
          OP_RD_LO: begin
            if (sel_ok) begin
              data_out <= sel_val[WIDTH-1:0];
              data_oe  <= 1'b1;
            end
          end
          OP_RD_HI: begin
            if (sel_ok) begin
              data_out <= sel_val[PW-1:WIDTH];
              data_oe  <= 1'b1;
            end
          end
          OP_LD_ADDR: begin
            if (sel_ok) addr_q <= sel_val;
          end
          OP_INCDEC: begin
            if (sel_ok) begin
              addr_q   <= sel_val;
              wb_sel_q <= sel;
              incdec_q <= dec ? sel_val - PW'(1)
                              : sel_val + PW'(1);
            end
          end
          OP_XCHG: begin
            pair_q[DE] <= pair_q[HL];
            pair_q[HL] <= pair_q[DE];
          end
          default: ;
        endcase
        if (!sel_ok && cmd != OP_NOP && cmd != OP_XCHG)
          err <= 1'b1;
      end
    end
  end

endmodule
